// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS-Lite pipeline: load-use bubbles,
// taken-branch flushes, data-memory req/ack freeze with timeout, stall counter.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_wn,
    input  logic             branch_taken,
    input  logic             mem_MemRead,
    input  logic             mem_MemWrite,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state_reg, state_next;
    logic [WC_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic              mem_err_reg, mem_err_next;
    logic [CNT_W-1:0]  stall_cycles_reg;

    logic memop;
    logic load_use;
    logic freeze;

    assign memop    = mem_MemRead | mem_MemWrite;
    // $0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = ex_MemRead && (ex_wn != 5'd0) &&
                      ((ex_wn == id_rs) || (id_uses_rt && (ex_wn == id_rt)));

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = mem_err_reg;
        freeze        = 1'b0;
        dmem_req      = 1'b0;
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        ifid_flush    = 1'b0;
        idex_we       = 1'b1;
        idex_flush    = 1'b0;
        exmem_we      = 1'b1;
        memwb_flush   = 1'b0;

        if (rst) begin
            state_next    = RUN;
            wait_cnt_next = '0;
            mem_err_next  = 1'b0;
            pc_we         = 1'b0;
            ifid_we       = 1'b0;
            idex_we       = 1'b0;
            exmem_we      = 1'b0;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            memwb_flush   = 1'b1;
        end else begin
            case (state_reg)
                RUN: begin
                    if (memop) begin
                        dmem_req = 1'b1;
                        if (!dmem_ack) begin
                            freeze        = 1'b1;
                            state_next    = MEM_WAIT;
                            wait_cnt_next = WC_W'(1);
                        end
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        state_next    = RUN;
                        wait_cnt_next = '0;
                    end else if (wait_cnt_reg == WC_W'(MEM_TIMEOUT)) begin
                        // Give up on the memory and let the pipeline move on.
                        mem_err_next  = 1'b1;
                        state_next    = RUN;
                        wait_cnt_next = '0;
                    end else begin
                        freeze        = 1'b1;
                        wait_cnt_next = wait_cnt_reg + WC_W'(1);
                    end
                end
                default: begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            endcase

            if (freeze) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_we     = 1'b0;
                exmem_we    = 1'b0;
                memwb_flush = 1'b1;
            end else if (branch_taken) begin
                // The ID instruction is wrong-path, so any load-use stall is moot.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= RUN;
            wait_cnt_reg     <= '0;
            mem_err_reg      <= 1'b0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
            if (!pc_we && (stall_cycles_reg != {CNT_W{1'b1}}))
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
        end
    end

    assign mem_err      = mem_err_reg;
    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard/memory scenarios then
// randomized traffic, checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CW    = 8;
    localparam int SMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_wn;
    logic          id_uses_rt, ex_MemRead, branch_taken;
    logic          mem_MemRead, mem_MemWrite, dmem_ack;
    logic          dmem_req, pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
    logic          exmem_we, memwb_flush, mem_err;
    logic [CW-1:0] stall_cycles;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_wn(ex_wn), .branch_taken(branch_taken),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_we(idex_we), .idex_flush(idex_flush), .exmem_we(exmem_we),
        .memwb_flush(memwb_flush), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          req, pc, ifid, ifidf, idex, idexf, exmem, memwbf, err;
        logic [CW-1:0] stalls;
    } out_t;

    out_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   vec_id = 0;

    // Reference model state: waiting on memory, MEM_WAIT cycles seen, error, stall count.
    bit   m_wait = 0;
    int   m_cnt = 0;
    bit   m_err = 0;
    int   m_stalls = 0;

    task automatic apply(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                         input bit urt, input bit exr, input logic [4:0] wn,
                         input bit br, input bit mr, input bit mw, input bit ack);
        out_t e;
        bit   frozen, done, lu;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_MemRead = exr;
        ex_wn = wn; branch_taken = br; mem_MemRead = mr; mem_MemWrite = mw; dmem_ack = ack;

        e.err    = m_err;
        e.stalls = CW'(m_stalls);
        if (r) begin
            e.req = 0; e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0;
            e.ifidf = 1; e.idexf = 1; e.memwbf = 1;
            m_wait = 0; m_cnt = 0; m_err = 0; m_stalls = 0;
        end else begin
            e.req = m_wait || mr || mw;
            // Memory is done this cycle if acked, or if the wait budget is exhausted.
            done   = ack || (m_wait && m_cnt == TO);
            frozen = e.req && !done;
            lu     = exr && wn != 0 && (wn == rs || (urt && wn == rt));
            e.pc = 1; e.ifid = 1; e.idex = 1; e.exmem = 1;
            e.ifidf = 0; e.idexf = 0; e.memwbf = 0;
            if (frozen) begin
                e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; e.memwbf = 1;
            end else if (br) begin
                e.ifidf = 1; e.idexf = 1;
            end else if (lu) begin
                e.pc = 0; e.ifid = 0; e.idexf = 1;
            end
            if (m_wait && !ack && m_cnt == TO) m_err = 1;
            if (frozen) begin
                m_wait = 1;
                m_cnt  = m_cnt + 1;
            end else begin
                m_wait = 0;
                m_cnt  = 0;
            end
            if (!e.pc && m_stalls < SMAX) m_stalls++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        apply(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        out_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{dmem_req, pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
                  exmem_we, memwb_flush, mem_err, stall_cycles};
            vectors++;
            vec_id++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs vec %0d: got req/pc/ifid/ifidf/idex/idexf/exmem/memwbf/err=%b%b%b%b%b%b%b%b%b stalls=%0d, expected %b%b%b%b%b%b%b%b%b stalls=%0d",
                         vec_id, a.req, a.pc, a.ifid, a.ifidf, a.idex, a.idexf, a.exmem,
                         a.memwbf, a.err, a.stalls, e.req, e.pc, e.ifid, e.ifidf, e.idex,
                         e.idexf, e.exmem, e.memwbf, e.err, e.stalls);
            end else begin
                $display("vec %0d ok: req=%b pc_we=%b stalls=%0d err=%b",
                         vec_id, a.req, a.pc, a.stalls, a.err);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit mr, mw, ack, exp_req;
        rst = 1; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_MemRead = 0; ex_wn = 0;
        branch_taken = 0; mem_MemRead = 0; mem_MemWrite = 0; dmem_ack = 0;

        apply(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        apply(1, 5'd3, 5'd3, 1, 1, 5'd3, 1, 1, 1, 0);
        idle();
        // lw $2 in EX, add reads $2 as rs: one bubble, then the load is gone.
        apply(0, 5'd2, 5'd7, 1, 1, 5'd2, 0, 0, 0, 0);
        apply(0, 5'd2, 5'd7, 1, 0, 5'd9, 0, 0, 0, 0);
        // Loads into $0 and rt-only matches with rt unused never stall.
        apply(0, 5'd0, 5'd4, 1, 1, 5'd0, 0, 0, 0, 0);
        apply(0, 5'd1, 5'd5, 0, 1, 5'd5, 0, 0, 0, 0);
        apply(0, 5'd1, 5'd5, 1, 1, 5'd5, 0, 0, 0, 0);
        // Taken branch overrides a simultaneous load-use.
        apply(0, 5'd6, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0);
        // sw with ack on the fourth request cycle.
        for (int i = 0; i < 4; i++) apply(0, 5'd1, 5'd2, 1, 0, 5'd0, i == 1, 0, 1, i == 3);
        idle();
        // Zero-wait accesses back to back.
        for (int i = 0; i < 3; i++) apply(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0, 1);
        // Timeout: no ack ever.
        for (int i = 0; i < TO + 1; i++) apply(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0, 0);
        idle();
        // Reset in the middle of a memory wait.
        apply(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 0);
        apply(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 0);
        apply(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, 0);
        idle();
        idle();

        for (int n = 0; n < 2500; n++) begin
            mr = ($urandom_range(0, 5) == 0);
            mw = !mr && ($urandom_range(0, 6) == 0);
            exp_req = m_wait || mr || mw;
            ack = exp_req && ($urandom_range(0, 3) == 0);
            apply(0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), mr, mw, ack);
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
